boot_loader: RTL and testbench
==============================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 The block SHALL have parameter MAX_WORDS, default 256, meaning the largest accepted program length in 32-bit words.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning the width of the instruction address output.
REQ-003 Port clk  input  1  rising-edge clock; one clock drives the whole block.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port byte_valid  input  1  upstream byte stream valid.
REQ-006 Port byte_data  input  8  upstream byte.
REQ-007 Port byte_ready  output  1  loader accepts a byte; a transfer occurs on an edge with byte_valid and byte_ready both high.
REQ-008 Port initialize  output  1  instruction-memory write mode to the CPU.
REQ-009 Port instruction_initialize_address  output  ADDR_W  byte address of the word being written.
REQ-010 Port instruction_initialize_data  output  32  instruction word being written.
REQ-011 Port cpu_rst  output  1  reset to the CPU core.
REQ-012 Port done  output  1  load completed successfully (sticky).
REQ-013 Port error  output  1  load failed (sticky).
REQ-014 Port words_loaded  output  16  count of words delivered.

Function
REQ-015 Stream format SHALL be a 2-byte big-endian word count N, followed by N words of 4 bytes each, most-significant byte first.
REQ-016 States SHALL be CNT_HI, CNT_LO, DATA, HOLD, CHK (macro only), DONE and ERR; the reset state is CNT_HI.
REQ-017 CNT_HI accepts the count MSB -> CNT_LO; CNT_LO accepts the count LSB -> DATA if 0<N<=MAX_WORDS, HOLD-bypass to DONE/CHK if N==0, ERR if N>MAX_WORDS.
REQ-018 In DATA, bytes SHALL shift into a private 32-bit assembly register; outputs SHALL NOT change on bytes 1-3 of a word.
REQ-019 On the edge accepting byte 4 of word k (0-based), instruction_initialize_data SHALL load the full word, instruction_initialize_address SHALL load 4*k, and words_loaded SHALL load k+1, all on the same edge.
REQ-020 After the last word, the state SHALL go to HOLD for exactly one cycle with byte_ready low, so the final word is presented for at least one cycle with initialize high, and then to CHK (macro) or DONE.
REQ-021 Address arithmetic SHALL be modulo 2^ADDR_W, with no wrap check beyond MAX_WORDS.
REQ-022 byte_ready SHALL be high in CNT_HI, CNT_LO, DATA and CHK, and low in HOLD, DONE and ERR.
REQ-023 In DONE: initialize=0, cpu_rst=0, done=1, and address/data hold their last values.
REQ-024 In ERR: initialize=1, cpu_rst=1, error=1; ERR and DONE are left only by rst.
REQ-025 A byte offered in HOLD, DONE or ERR SHALL be ignored.

Reset
REQ-026 rst SHALL return the block to CNT_HI from any state, including mid-word; a partially assembled word SHALL be discarded.
REQ-027 Reset values SHALL be: initialize=1, cpu_rst=1, address=0, data=0, done=0, error=0, words_loaded=0, byte_ready=1 (first cycle after the rst edge).

Configuration
REQ-028 Macro BOOT_LOADER_CHECKSUM_EN SHALL control checksum checking.
REQ-029 With BOOT_LOADER_CHECKSUM_EN defined, one trailing byte equal to the XOR of all 4N payload bytes SHALL be accepted in CHK; a match -> DONE, a mismatch -> ERR.
REQ-030 Without BOOT_LOADER_CHECKSUM_EN, the CHK state and the XOR register SHALL NOT exist, and HOLD or N==0 SHALL go directly to DONE.

Verification
REQ-031 Bytes 00 02 | 00 02 08 20 | 8C 0C 00 0C, back-to-back valid -> addr0=0x00020820, then addr4=0x8C0C000C; HOLD 1 cycle; then initialize=0, cpu_rst=0, done=1, words_loaded=2.
REQ-032 Same stream with byte_valid toggled every other cycle -> identical outputs, and the address/data pair changes only on 4th-byte edges.
REQ-033 Count 0x0101 (257) with default MAX_WORDS -> error=1 one cycle after the LSB, byte_ready=0, cpu_rst stays 1.
REQ-034 rst pulsed after byte 2 of word 0 -> outputs return to reset values; a fresh 1-word load then writes address 0 correctly.
REQ-035 Checksum macro on: 1 word AA 55 0F F0 with checksum 0x00 -> done=1; with checksum 0x01 -> error=1, initialize stays 1.
REQ-036 Count 0 -> done=1 two cycles after the LSB (macro off), and words_loaded=0.

Source files
------------

// File: rtl/boot_loader.sv
// Byte-stream boot loader: assembles big-endian 32-bit words and writes them into CPU instruction memory.
// Optional trailing XOR checksum byte enabled by defining BOOT_LOADER_CHECKSUM_EN.
module boot_loader #(
   parameter int MAX_WORDS = 256,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              initialize,
   output logic [ADDR_W-1:0] instruction_initialize_address,
   output logic [31:0]       instruction_initialize_data,
   output logic              cpu_rst,
   output logic              done,
   output logic              error,
   output logic [15:0]       words_loaded
);

   // A byte moves on a rising edge only when byte_valid and byte_ready are both high;
   // byte_ready depends on the state alone, never on byte_valid.
   typedef enum logic [2:0] {
      CNT_HI,
      CNT_LO,
      DATA,
      HOLD,
`ifdef BOOT_LOADER_CHECKSUM_EN
      CHK,
`endif
      DONE,
      ERR
   } state_t;

   localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

   state_t      state;
   logic [7:0]  cnt_hi_q;
   logic [15:0] total_q;
   logic [1:0]  byte_idx;
   logic [23:0] asm_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
   logic [7:0]  xor_q;
`endif

   logic              take;
   logic [15:0]       count_n;
   logic              last_word;
   logic [ADDR_W-1:0] word_addr;

   assign take      = byte_valid && byte_ready;
   assign count_n   = {cnt_hi_q, byte_data};
   assign last_word = (words_loaded + 16'd1) == total_q;
   // Byte address of the word currently completing; wraps naturally at 2^ADDR_W.
   assign word_addr = ADDR_W'({words_loaded, 2'b00});

   assign byte_ready = (state == CNT_HI) || (state == CNT_LO) || (state == DATA)
`ifdef BOOT_LOADER_CHECKSUM_EN
                       || (state == CHK)
`endif
                       ;

   always_ff @(posedge clk) begin
      if (rst) begin
         state                          <= CNT_HI;
         cnt_hi_q                       <= 8'd0;
         total_q                        <= 16'd0;
         byte_idx                       <= 2'd0;
         asm_q                          <= 24'd0;
`ifdef BOOT_LOADER_CHECKSUM_EN
         xor_q                          <= 8'd0;
`endif
         initialize                     <= 1'b1;
         cpu_rst                        <= 1'b1;
         instruction_initialize_address <= '0;
         instruction_initialize_data    <= 32'd0;
         done                           <= 1'b0;
         error                          <= 1'b0;
         words_loaded                   <= 16'd0;
      end else begin
         case (state)
            CNT_HI: begin
               if (take) begin
                  cnt_hi_q <= byte_data;
                  state    <= CNT_LO;
               end
            end
            CNT_LO: begin
               if (take) begin
                  total_q  <= count_n;
                  byte_idx <= 2'd0;
                  if ({1'b0, count_n} > MAX_N) begin
                     state <= ERR;
                     error <= 1'b1;
                  end else if (count_n == 16'd0) begin
                     state <= HOLD;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (take) begin
                  byte_idx <= byte_idx + 2'd1;
                  asm_q    <= {asm_q[15:0], byte_data};
`ifdef BOOT_LOADER_CHECKSUM_EN
                  xor_q    <= xor_q ^ byte_data;
`endif
                  // Outputs move only when the fourth byte completes a word.
                  if (byte_idx == 2'd3) begin
                     instruction_initialize_data    <= {asm_q, byte_data};
                     instruction_initialize_address <= word_addr;
                     words_loaded                   <= words_loaded + 16'd1;
                     if (last_word) state <= HOLD;
                  end
               end
            end
            HOLD: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
               state      <= CHK;
`else
               state      <= DONE;
               initialize <= 1'b0;
               cpu_rst    <= 1'b0;
               done       <= 1'b1;
`endif
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            CHK: begin
               if (take) begin
                  if (byte_data == xor_q) begin
                     state      <= DONE;
                     initialize <= 1'b0;
                     cpu_rst    <= 1'b0;
                     done       <= 1'b1;
                  end else begin
                     state <= ERR;
                     error <= 1'b1;
                  end
               end
            end
`endif
            DONE: state <= DONE;
            ERR:  state <= ERR;
            default: begin
               state <= ERR;
               error <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: vector table, hand-written timing sequences and random streams
// checked against a stream-level reference model; honours BOOT_LOADER_CHECKSUM_EN.
module tb_boot_loader;

   localparam int MAXW = 256;
   localparam int AW   = 32;
`ifdef BOOT_LOADER_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   logic          clk;
   logic          rst;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          initialize;
   logic [AW-1:0] instruction_initialize_address;
   logic [31:0]   instruction_initialize_data;
   logic          cpu_rst;
   logic          done;
   logic          error;
   logic [15:0]   words_loaded;

   boot_loader #(.MAX_WORDS(MAXW), .ADDR_W(AW)) dut (
      .clk                            (clk),
      .rst                            (rst),
      .byte_valid                     (byte_valid),
      .byte_data                      (byte_data),
      .byte_ready                     (byte_ready),
      .initialize                     (initialize),
      .instruction_initialize_address (instruction_initialize_address),
      .instruction_initialize_data    (instruction_initialize_data),
      .cpu_rst                        (cpu_rst),
      .done                           (done),
      .error                          (error),
      .words_loaded                   (words_loaded)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit stalled = 1'b0;

   // scoreboard entries: {address, data, words_loaded}
   logic [79:0] exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: got no valid response expected one", name);
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      stalled = 1'b0;
      exp_q.delete();
   endtask

   // ---------------- driver ----------------
   task automatic send_byte(input logic [7:0] b, input bit gap);
      int waited;
      if (stalled) return;
      if (gap) begin
         byte_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      byte_valid = 1'b1;
      byte_data  = b;
      waited     = 0;
      while (byte_ready !== 1'b1 && waited < 40) begin
         @(posedge clk);
         #1;
         waited++;
      end
      if (byte_ready !== 1'b1) begin
         fail_now("byte_accept_timeout");
         stalled    = 1'b1;
         byte_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   task automatic offer_junk();
      byte_valid = 1'b1;
      byte_data  = 8'h5A;
      repeat (3) @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] xsum(input logic [7:0] s[$]);
      logic [7:0] x = 8'h00;
      for (int i = 2; i < s.size(); i++) x ^= s[i];
      return x;
   endfunction

   task automatic model(input logic [7:0] s[$], output bit e_done, output bit e_err,
                        output int used, output logic [15:0] e_wl,
                        output logic [31:0] e_addr, output logic [31:0] e_data);
      int n;
      logic [7:0] x;
      n = int'(s[0]) * 256 + int'(s[1]);
      e_done = 1'b0; e_err = 1'b0; e_wl = 16'd0; e_addr = 32'd0; e_data = 32'd0; x = 8'h00;
      if (n > MAXW) begin
         e_err = 1'b1;
         used  = 2;
         return;
      end
      for (int k = 0; k < n; k++) begin
         e_data = {s[2+4*k], s[3+4*k], s[4+4*k], s[5+4*k]};
         e_addr = 32'(4 * k);
         e_wl   = 16'(k + 1);
         x      = x ^ s[2+4*k] ^ s[3+4*k] ^ s[4+4*k] ^ s[5+4*k];
         exp_q.push_back({e_addr, e_data, e_wl});
      end
      used = 2 + 4 * n;
`ifdef BOOT_LOADER_CHECKSUM_EN
      if (s[used] == x) e_done = 1'b1;
      else e_err = 1'b1;
      used++;
`else
      e_done = 1'b1;
`endif
   endtask

   task automatic check_final(input string name, input bit e_done, input bit e_err,
                              input logic [15:0] e_wl, input logic [31:0] e_addr,
                              input logic [31:0] e_data);
      repeat (3) @(posedge clk);
      #1;
      chk({name, "_done"}, done, e_done);
      chk({name, "_error"}, error, e_err);
      chk({name, "_init"}, initialize, !e_done);
      chk({name, "_cpu_rst"}, cpu_rst, !e_done);
      chk({name, "_ready"}, byte_ready, 1'b0);
      chk({name, "_words"}, words_loaded, e_wl);
      chk({name, "_addr"}, instruction_initialize_address, e_addr);
      chk({name, "_data"}, instruction_initialize_data, e_data);
      chk({name, "_pending"}, exp_q.size(), 0);
   endtask

   task automatic run_stream(input string name, input logic [7:0] s[$], input int gap);
      bit ed, ee;
      int used;
      logic [15:0] wl;
      logic [31:0] a, d;
      model(s, ed, ee, used, wl, a, d);
      for (int i = 0; i < used; i++)
         send_byte(s[i], gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0));
      offer_junk();
      check_final(name, ed, ee, wl, a, d);
   endtask

   task automatic check_reset_values(input string name);
      chk({name, "_init"}, initialize, 1'b1);
      chk({name, "_cpu_rst"}, cpu_rst, 1'b1);
      chk({name, "_addr"}, instruction_initialize_address, 32'd0);
      chk({name, "_data"}, instruction_initialize_data, 32'd0);
      chk({name, "_done"}, done, 1'b0);
      chk({name, "_error"}, error, 1'b0);
      chk({name, "_words"}, words_loaded, 16'd0);
      chk({name, "_ready"}, byte_ready, 1'b1);
   endtask

   // ---------------- write monitor ----------------
   logic [15:0] prev_wl;
   logic [31:0] prev_addr, prev_data;
   logic [79:0] mon_e;

   always @(negedge clk) begin
      if (words_loaded !== prev_wl) begin
         if (words_loaded != 16'd0) begin
            if (exp_q.size() == 0) fail_now("unexpected_write");
            else begin
               mon_e = exp_q.pop_front();
               chk("wr_addr", instruction_initialize_address, mon_e[79:48]);
               chk("wr_data", instruction_initialize_data, mon_e[47:16]);
               chk("wr_count", words_loaded, mon_e[15:0]);
            end
         end
      end else if (instruction_initialize_address !== prev_addr ||
                   instruction_initialize_data !== prev_data) begin
         chk("write_without_count", {instruction_initialize_address, instruction_initialize_data},
             {prev_addr, prev_data});
      end
      prev_wl   = words_loaded;
      prev_addr = instruction_initialize_address;
      prev_data = instruction_initialize_data;
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic [95:0] bytes;
      int          len;
      bit          e_done;
      bit          e_err;
      logic [15:0] e_wl;
      logic [31:0] e_addr;
      logic [31:0] e_data;
   } vec_t;

   vec_t vecs[5];
   logic [7:0] s[$];

   initial begin
      bit ed, ee;
      int used, n;
      logic [15:0] wl;
      logic [31:0] a, d;

      vecs[0] = '{96'h0002_0002_0820_8C0C_000C_A600, 10 + CK, 1'b1, 1'b0, 16'd2, 32'h4, 32'h8C0C000C};
      vecs[1] = '{96'h0101_0000_0000_0000_0000_0000, 2, 1'b0, 1'b1, 16'd0, 32'h0, 32'h0};
      vecs[2] = '{96'h0000_0000_0000_0000_0000_0000, 2 + CK, 1'b1, 1'b0, 16'd0, 32'h0, 32'h0};
      vecs[3] = '{96'h0001_AA55_0FF0_0000_0000_0000, 6 + CK, 1'b1, 1'b0, 16'd1, 32'h0, 32'hAA550FF0};
`ifdef BOOT_LOADER_CHECKSUM_EN
      vecs[4] = '{96'h0001_AA55_0FF0_0100_0000_0000, 7, 1'b0, 1'b1, 16'd1, 32'h0, 32'hAA550FF0};
`else
      vecs[4] = '{96'hFFFF_0000_0000_0000_0000_0000, 2, 1'b0, 1'b1, 16'd0, 32'h0, 32'h0};
`endif

      rst = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
      prev_wl = 16'd0; prev_addr = 32'd0; prev_data = 32'd0;
      do_reset();
      check_reset_values("reset");

      for (int i = 0; i < 5; i++) begin
         do_reset();
         s.delete();
         for (int j = 0; j < vecs[i].len; j++) s.push_back(vecs[i].bytes[95-8*j -: 8]);
         model(s, ed, ee, used, wl, a, d);
         for (int j = 0; j < vecs[i].len; j++) send_byte(s[j], 1'b0);
         offer_junk();
         check_final($sformatf("vec%0d", i), vecs[i].e_done, vecs[i].e_err, vecs[i].e_wl,
                     vecs[i].e_addr, vecs[i].e_data);
      end

      // two-word load back-to-back: final word held one cycle with byte_ready low
      do_reset();
      s = '{8'h00, 8'h02, 8'h00, 8'h02, 8'h08, 8'h20, 8'h8C, 8'h0C, 8'h00, 8'h0C};
      if (CK == 1) s.push_back(8'hA6);
      model(s, ed, ee, used, wl, a, d);
      for (int j = 0; j < 10; j++) send_byte(s[j], 1'b0);
      chk("hold_ready", byte_ready, 1'b0);
      chk("hold_init", initialize, 1'b1);
      chk("hold_done", done, 1'b0);
      chk("hold_data", instruction_initialize_data, 32'h8C0C000C);
      chk("hold_addr", instruction_initialize_address, 32'h4);
      @(posedge clk);
      #1;
`ifdef BOOT_LOADER_CHECKSUM_EN
      chk("chk_ready", byte_ready, 1'b1);
      chk("chk_done", done, 1'b0);
      send_byte(8'hA6, 1'b0);
`endif
      chk("after_hold_done", done, 1'b1);
      chk("after_hold_init", initialize, 1'b0);
      chk("after_hold_cpu_rst", cpu_rst, 1'b0);
      chk("after_hold_words", words_loaded, 16'd2);
      chk("after_hold_pending", exp_q.size(), 0);

      // same stream with valid toggling every other cycle
      do_reset();
      run_stream("toggle", s, 1);

      // oversize count: error the cycle after the LSB
      do_reset();
      send_byte(8'h01, 1'b0);
      send_byte(8'h01, 1'b0);
      chk("ovf_error", error, 1'b1);
      chk("ovf_ready", byte_ready, 1'b0);
      chk("ovf_cpu_rst", cpu_rst, 1'b1);
      chk("ovf_init", initialize, 1'b1);

      // zero-length program passes through HOLD
      do_reset();
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      chk("zero_done_early", done, 1'b0);
      chk("zero_ready_hold", byte_ready, 1'b0);
      @(posedge clk);
      #1;
`ifdef BOOT_LOADER_CHECKSUM_EN
      chk("zero_chk_ready", byte_ready, 1'b1);
      send_byte(8'h00, 1'b0);
`endif
      chk("zero_done", done, 1'b1);
      chk("zero_words", words_loaded, 16'd0);

      // reset in the middle of a word, then a fresh one-word load
      do_reset();
      send_byte(8'h00, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      do_reset();
      check_reset_values("midword_reset");
      s = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      if (CK == 1) s.push_back(xsum(s));
      run_stream("after_reset", s, 0);

      // largest accepted program
      do_reset();
      s = '{8'h01, 8'h00};
      for (int j = 0; j < 4 * MAXW; j++) s.push_back(8'($urandom_range(0, 255)));
      if (CK == 1) s.push_back(xsum(s));
      run_stream("max_words", s, 0);

      // random streams
      for (int it = 0; it < 30; it++) begin
         do_reset();
         if ($urandom_range(0, 9) == 0) n = $urandom_range(MAXW + 1, 65535);
         else n = $urandom_range(0, 5);
         s = '{8'(n >> 8), 8'(n)};
         if (n <= MAXW) begin
            for (int j = 0; j < 4 * n; j++) s.push_back(8'($urandom_range(0, 255)));
            if (CK == 1) begin
               if ($urandom_range(0, 3) == 0) s.push_back(xsum(s) ^ 8'($urandom_range(1, 255)));
               else s.push_back(xsum(s));
            end
         end
         run_stream($sformatf("rand%0d", it), s, 2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
